// File: rtl/serial_parity_tx.sv
// serial_parity_tx: LSB-first parallel-to-serial transmitter with a trailing parity bit.
// The SERIAL_PARITY_ODD_EN macro selects odd parity; the default build sends even parity.
module serial_parity_tx #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             ser_out,
    output logic             ser_valid,
    input  logic             ser_ready,
    output logic             ser_last,
    output logic             busy
);
    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
`ifdef SERIAL_PARITY_ODD_EN
    localparam logic POL = 1'b1;
`else
    localparam logic POL = 1'b0;
`endif
    typedef enum logic [1:0] {IDLE, SHIFT, PARITY} state_t;
    state_t state, state_nx;
    logic [WIDTH-1:0] shreg, shreg_nx;
    logic [CW-1:0] count, count_nx;
    logic parity, parity_nx;
    logic accept;
    assign busy = state != IDLE;
    // Register all frame state; reset aborts any frame in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            shreg  <= '0;
            count  <= '0;
            parity <= 1'b0;
        end else begin
            state  <= state_nx;
            shreg  <= shreg_nx;
            count  <= count_nx;
            parity <= parity_nx;
        end
    end
    // Next-state and handshake decode; an accept (IDLE or PARITY end) always restarts a frame.
    always_comb begin
        in_ready  = 1'b0;
        ser_valid = 1'b0;
        ser_out   = 1'b0;
        ser_last  = 1'b0;
        state_nx  = state;
        shreg_nx  = shreg;
        count_nx  = count;
        parity_nx = parity;
        case (state)
            IDLE: in_ready = rst_n;
            SHIFT: begin
                ser_valid = 1'b1;
                ser_out   = shreg[0];
                if (ser_ready) begin
                    parity_nx = parity ^ shreg[0];
                    shreg_nx  = shreg >> 1;
                    count_nx  = count + 1'b1;
                    state_nx  = (count == LAST) ? PARITY : SHIFT;
                end
            end
            PARITY: begin
                ser_valid = 1'b1;
                ser_last  = 1'b1;
                ser_out   = parity ^ POL;
                in_ready  = ser_ready;
                if (ser_ready) begin
                    state_nx = IDLE;
                    count_nx = '0;
                end
            end
            default: state_nx = IDLE;
        endcase
        accept = in_valid & in_ready;
        if (accept) begin
            state_nx  = SHIFT;
            shreg_nx  = in_data;
            count_nx  = '0;
            parity_nx = 1'b0;
        end
    end
endmodule
